// File: rtl/pc_seq_ctrl.sv
// Fetch/decode/execute sequencer between instruction memory, the ALU and the PC block.
// Define PCSEQ_SINGLE_STEP_EN to add the step input and the STEP_WAIT state.
//
// state        | meaning
// S_IDLE       | first cycle after reset release
// S_FETCH      | imem_req high, waiting for imem_ack (bounded by TMO)
// S_DECODE     | opcode in IR selects the next phase
// S_EXEC       | alu_en strobe, flags captured at end of cycle
// S_UPDATE     | pc_en strobe with jump/branch selects
// S_HALT       | halted, absorbing until reset
// S_FAULT      | fetch timeout, absorbing until reset
// S_STEP_WAIT  | (single-step build) waiting for step before next fetch

module pc_seq_ctrl #(
   parameter int IW  = 16,
   parameter int LW  = 9,
   parameter int TMO = 15
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   input  logic          imem_ack,
`ifdef PCSEQ_SINGLE_STEP_EN
   input  logic          step,
`endif
   input  logic [IW-1:0] instr,
   output logic          alu_en,
   input  logic          alu_n,
   input  logic          alu_z,
   input  logic          alu_v,
   input  logic          alu_c,
   output logic          pc_en,
   output logic          j_sele,
   output logic          pc_sele,
   output logic [LW-1:0] adr_in,
   output logic [LW-1:0] label,
   output logic [2:0]    funct,
   output logic          neg,
   output logic          zer,
   output logic          ovf,
   output logic          car,
   output logic          halted,
   output logic          fault
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT, S_FAULT
`ifdef PCSEQ_SINGLE_STEP_EN
      , S_STEP_WAIT
`endif
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

   state_t        state;
   logic [IW-1:0] ir;
   logic [7:0]    wait_cnt;
   logic [3:0]    op;
   logic          br_taken;

   assign op     = ir[IW-1 -: 4];
   assign adr_in = ir[LW-1:0];
   assign label  = ir[LW-1:0];
   assign funct  = ir[11:9];

   // Branch decision uses the registered flags from the most recent ALU op.
   always_comb begin
      br_taken = 1'b0;
      case (funct)
         3'd1:    br_taken = neg;
         3'd2:    br_taken = zer;
         3'd3:    br_taken = ovf;
         3'd4:    br_taken = car;
         default: br_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         ir       <= '0;
         wait_cnt <= '0;
         imem_req <= 1'b0;
         alu_en   <= 1'b0;
         pc_en    <= 1'b0;
         j_sele   <= 1'b0;
         pc_sele  <= 1'b0;
         neg      <= 1'b0;
         zer      <= 1'b0;
         ovf      <= 1'b0;
         car      <= 1'b0;
         halted   <= 1'b0;
         fault    <= 1'b0;
      end else begin
         alu_en  <= 1'b0;
         pc_en   <= 1'b0;
         j_sele  <= 1'b0;
         pc_sele <= 1'b0;
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
               wait_cnt <= '0;
            end
            S_FETCH: begin
               // An ack arriving on the last allowed cycle still wins over the timeout.
               if (imem_ack) begin
                  ir       <= instr;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else if (wait_cnt == TMO_LAST) begin
                  imem_req <= 1'b0;
                  fault    <= 1'b1;
                  state    <= S_FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: begin
               if (op <= 4'hB) begin
                  alu_en <= 1'b1;
                  state  <= S_EXEC;
               end else if (op == 4'hF) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  pc_en   <= 1'b1;
                  j_sele  <= (op == 4'hC);
                  pc_sele <= (op == 4'hD) && br_taken;
                  state   <= S_UPDATE;
               end
            end
            S_EXEC: begin
               neg   <= alu_n;
               zer   <= alu_z;
               ovf   <= alu_v;
               car   <= alu_c;
               pc_en <= 1'b1;
               state <= S_UPDATE;
            end
            S_UPDATE: begin
`ifdef PCSEQ_SINGLE_STEP_EN
               state <= S_STEP_WAIT;
`else
               state    <= S_FETCH;
               imem_req <= 1'b1;
               wait_cnt <= '0;
`endif
            end
`ifdef PCSEQ_SINGLE_STEP_EN
            S_STEP_WAIT: begin
               if (step) begin
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
                  wait_cnt <= '0;
               end
            end
`endif
            S_HALT:  state <= S_HALT;
            S_FAULT: state <= S_FAULT;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: builds a per-cycle expected timeline from each program
// and compares every cycle, plus literal checks on directed programs.

module tb_pc_seq_ctrl;

   localparam int TMO = 15;
   localparam int PAD = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_ack = 1'b0;
   logic [15:0] instr = '0;
   logic        alu_n = 1'b0, alu_z = 1'b0, alu_v = 1'b0, alu_c = 1'b0;
   logic        imem_req, alu_en, pc_en, j_sele, pc_sele;
   logic [8:0]  adr_in, label;
   logic [2:0]  funct;
   logic        neg, zer, ovf, car, halted, fault;
`ifdef PCSEQ_SINGLE_STEP_EN
   logic        step = 1'b1;
`endif

   pc_seq_ctrl #(.IW(16), .LW(9), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack),
`ifdef PCSEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .instr(instr), .alu_en(alu_en), .alu_n(alu_n), .alu_z(alu_z),
      .alu_v(alu_v), .alu_c(alu_c), .pc_en(pc_en), .j_sele(j_sele),
      .pc_sele(pc_sele), .adr_in(adr_in), .label(label), .funct(funct),
      .neg(neg), .zer(zer), .ovf(ovf), .car(car), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req, alu, pc, j, p, hlt, flt;
      logic [8:0] adr;
      logic [2:0] fn;
      logic [3:0] flg;
   } out_t;

   typedef struct packed {
      logic        ack;
      logic [15:0] ins;
      logic [3:0]  af;
   } stim_t;

   out_t        exp_q[$];
   stim_t       stim_q[$];
   out_t        obs[$];
   logic [15:0] p_ins[$];
   int          p_dly[$];
   logic [3:0]  p_flg[$];
   logic [15:0] m_ir;
   logic [3:0]  m_flg;
   int          tests = 0;
   int          fails = 0;

   function automatic out_t mk(logic req, logic alu, logic pc, logic j, logic p,
                               logic hlt, logic flt);
      out_t e;
      e.req = req; e.alu = alu; e.pc = pc; e.j = j; e.p = p;
      e.hlt = hlt; e.flt = flt;
      e.adr = m_ir[8:0];
      e.fn  = m_ir[11:9];
      e.flg = m_flg;
      return e;
   endfunction

   function automatic stim_t rnd_stim();
      stim_t s;
      s.ack = 1'($urandom);
      s.ins = 16'($urandom);
      s.af  = 4'($urandom);
      return s;
   endfunction

   // flags packed as {n,z,v,c}; funct 1..4 selects n,z,v,c in that order
   function automatic logic taken(logic [2:0] fn, logic [3:0] f);
      if (fn >= 3'd1 && fn <= 3'd4) return f[4 - int'(fn)];
      return 1'b0;
   endfunction

   task automatic push(out_t e, stim_t s);
      exp_q.push_back(e);
      stim_q.push_back(s);
   endtask

   task automatic add(logic [15:0] ins, int d, logic [3:0] f);
      p_ins.push_back(ins);
      p_dly.push_back(d);
      p_flg.push_back(f);
   endtask

   task automatic clear_prog();
      p_ins.delete(); p_dly.delete(); p_flg.delete();
   endtask

   // Expected timeline: one entry per clock cycle, starting with the IDLE cycle.
   task automatic build(int trunc);
      stim_t      s;
      logic [3:0] op;
      bit         done;
      int         d;
      done = 0;
      exp_q.delete(); stim_q.delete();
      m_ir = '0; m_flg = '0;
      push(mk(0, 0, 0, 0, 0, 0, 0), rnd_stim());
      for (int i = 0; i < p_ins.size() && !done; i++) begin
         d = p_dly[i];
         for (int w = 0; w < d && w < TMO; w++) begin
            s = rnd_stim(); s.ack = 1'b0;
            push(mk(1, 0, 0, 0, 0, 0, 0), s);
         end
         if (d >= TMO) begin
            repeat (PAD) push(mk(0, 0, 0, 0, 0, 0, 1), rnd_stim());
            done = 1;
         end else begin
            s = rnd_stim(); s.ack = 1'b1; s.ins = p_ins[i];
            push(mk(1, 0, 0, 0, 0, 0, 0), s);
            m_ir = p_ins[i];
            push(mk(0, 0, 0, 0, 0, 0, 0), rnd_stim());
            op = m_ir[15:12];
            if (op == 4'hF) begin
               repeat (PAD) push(mk(0, 0, 0, 0, 0, 1, 0), rnd_stim());
               done = 1;
            end else begin
               if (op <= 4'hB) begin
                  s = rnd_stim(); s.af = p_flg[i];
                  push(mk(0, 1, 0, 0, 0, 0, 0), s);
                  m_flg = p_flg[i];
               end
               push(mk(0, 0, 1, op == 4'hC, (op == 4'hD) && taken(m_ir[11:9], m_flg), 0, 0),
                    rnd_stim());
`ifdef PCSEQ_SINGLE_STEP_EN
               push(mk(0, 0, 0, 0, 0, 0, 0), rnd_stim());
`endif
            end
         end
      end
      if (!done) begin
         s = rnd_stim(); s.ack = 1'b0;
         push(mk(1, 0, 0, 0, 0, 0, 0), s);
      end
      if (trunc > 0 && trunc < exp_q.size()) begin
         exp_q  = exp_q[0:trunc-1];
         stim_q = stim_q[0:trunc-1];
      end
   endtask

   function automatic out_t sample();
      out_t a;
      a.req = imem_req; a.alu = alu_en; a.pc = pc_en; a.j = j_sele; a.p = pc_sele;
      a.hlt = halted; a.flt = fault; a.adr = adr_in; a.fn = funct;
      a.flg = {neg, zer, ovf, car};
      return a;
   endfunction

   task automatic check_out(string name, int k, out_t a, out_t e);
      tests++;
      if (a !== e || label !== e.adr) begin
         fails++;
         $display("FAIL %s cycle %0d: got %h label %h, expected %h label %h",
                  name, k, a, label, e, e.adr);
      end
   endtask

   task automatic lit(string name, logic [15:0] act, logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Releases reset, checks every cycle of the timeline, then resets mid-cycle.
   task automatic run(int trunc);
      out_t a;
      out_t z;
      z = '0;
      build(trunc);
      obs.delete();
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k > 0) @(negedge clk);
         #1;
         a = sample();
         obs.push_back(a);
         check_out("timeline", k, a, exp_q[k]);
         imem_ack = stim_q[k].ack;
         instr    = stim_q[k].ins;
         {alu_n, alu_z, alu_v, alu_c} = stim_q[k].af;
      end
      #2 rst = 1'b0;
      #1 check_out("async_reset", exp_q.size(), sample(), z);
      imem_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic gen_random();
      int n, kind, r, d;
      logic [15:0] ins;
      clear_prog();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 19);
         if (kind < 9)       ins = {4'($urandom_range(0, 11)), 12'($urandom)};
         else if (kind < 13) ins = {4'hD, 3'($urandom_range(0, 7)), 9'($urandom)};
         else if (kind < 16) ins = {4'hC, 12'($urandom)};
         else if (kind < 19) ins = {4'hE, 12'($urandom)};
         else                ins = {4'hF, 12'($urandom)};
         r = $urandom_range(0, 19);
         if (r < 12)       d = 0;
         else if (r < 17)  d = $urandom_range(1, 3);
         else if (r == 17) d = TMO - 1;
         else if (r == 18) d = TMO;
         else              d = $urandom_range(0, TMO - 2);
         add(ins, d, 4'($urandom));
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);

      clear_prog();
      add(16'hE000, 0, 4'h0);
      add(16'hE000, 0, 4'h0);
      run(0);
`ifndef PCSEQ_SINGLE_STEP_EN
      lit("nop_req_c1", obs[1].req, 1);
      lit("nop_pc_en_c2", obs[2].pc, 0);
      lit("nop_pc_en_c3", obs[3].pc, 1);
      lit("nop_sel_c3", {obs[3].j, obs[3].p}, 0);
      lit("nop_refetch_c4", obs[4].req, 1);
`endif

      clear_prog();
      add(16'h1234, 0, 4'b1000);
      add(16'hD205, 0, 4'h0);
      add(16'hD405, 0, 4'h0);
      add(16'h2000, 0, 4'b1111);
      add(16'hDC05, 0, 4'h0);
      add(16'hC1FF, 0, 4'h0);
      add(16'hF000, 0, 4'h0);
      run(0);
`ifndef PCSEQ_SINGLE_STEP_EN
      lit("alu_en_c3", obs[3].alu, 1);
      lit("alu_en_c4", obs[4].alu, 0);
      lit("neg_c4", obs[4].flg, 4'b1000);
      lit("br_taken_psel", obs[7].p, 1);
      lit("br_taken_label", obs[7].adr, 9'h005);
      lit("br_z_not_taken", {obs[10].j, obs[10].p}, 0);
      lit("br_f6_not_taken", {obs[17].pc, obs[17].p}, 2'b10);
      lit("jmp_sel", {obs[20].j, obs[20].p}, 2'b10);
      lit("jmp_adr", obs[20].adr, 9'h1FF);
      lit("jmp_flags_kept", obs[20].flg, 4'hF);
      lit("halted_c23", obs[23].hlt, 1);
      lit("halt_quiet", {obs[28].pc, obs[28].req}, 0);
`endif

      clear_prog();
      add(16'hE000, TMO, 4'h0);
      run(0);
      lit("tmo_req_last", obs[TMO].req, 1);
      lit("tmo_no_fault_yet", obs[TMO].flt, 0);
      lit("tmo_fault", obs[TMO+1].flt, 1);
      lit("tmo_req_drop", obs[TMO+1].req, 0);

      clear_prog();
      add(16'h1000, 0, 4'hF);
      add(16'h1000, 0, 4'h0);
      run(8);
      lit("exec_alu_en", obs[7].alu, 1);
      lit("exec_flags", obs[7].flg, 4'hF);

      for (int t = 0; t < 40; t++) begin
         gen_random();
         run(($urandom_range(0, 3) == 0) ? $urandom_range(2, 40) : 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multi-cycle fetch/decode/execute sequencer that drives the program-counter block (j_sele, pc_sele, adr_in, funct, label, neg/zer/ovf/car) and a clock-enable for it.
- Fetches 16-bit instructions over a req/ack handshake, holds them in an instruction register, and issues one ALU strobe per ALU instruction.
- Registers the ALU flags and advances the PC exactly once per instruction.
- Sits between instruction memory, the ALU and the PC.

Parameters:
- IW, 16, instruction width
- LW, 9, label / relative-offset width
- TMO, 15, max cycles waiting for imem_ack before fault (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid; instr sampled when imem_req & imem_ack
- instr  in  IW  instruction from memory
- alu_en  out  1  one-cycle ALU execute strobe
- alu_n, alu_z, alu_v, alu_c  in  1 each  ALU flags, valid in the alu_en cycle
- pc_en  out  1  PC update enable, one cycle per instruction
- j_sele  out  1  relative-jump select to PC
- pc_sele  out  1  taken-branch select to PC
- adr_in  out  LW  relative jump offset (IR[8:0])
- label  out  LW  branch target (IR[8:0])
- funct  out  3  branch condition (IR[11:9])
- neg, zer, ovf, car  out  1 each  registered flags to PC
- halted  out  1  HALT executed
- fault  out  1  fetch timeout occurred

Behaviour:
- Reset (rst low, async): state IDLE; IR=0; all flag registers 0; imem_req, alu_en, pc_en, j_sele, pc_sele, halted and fault all 0.
- adr_in, label and funct are combinational from IR, so they are 0 in reset.
- Opcode = IR[15:12]:
  - 0x0..0xB: ALU
  - 0xC: JMP, relative
  - 0xD: BR, conditional
  - 0xE: NOP
  - 0xF: HALT
- FSM states: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT, FAULT.
- IDLE: on the first clock after reset release, go to FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack: IR<=instr, go to DECODE.
  - The wait counter increments each cycle without ack. When it reaches TMO without ack, go to FAULT.
  - The counter clears on entry to FETCH.
- DECODE:
  - ALU goes to EXEC.
  - JMP, BR and NOP go to UPDATE.
  - HALT goes to HALT.
- EXEC: alu_en=1 for exactly one cycle; neg/zer/ovf/car <= alu_n/z/v/c at the end of that cycle; go to UPDATE.
- UPDATE: pc_en=1 for one cycle, then go to FETCH. Selects during UPDATE:
  - JMP: j_sele=1, pc_sele=0.
  - BR, taken: j_sele=0, pc_sele=1.
  - BR not taken, NOP, ALU: j_sele=0, pc_sele=0 (increment).
- Branch taken rule:
  - funct=1 & neg, funct=2 & zer, funct=3 & ovf, or funct=4 & car.
  - funct 0, 5, 6 and 7 are never taken.
- j_sele and pc_sele are 0 in every state other than UPDATE. They are never both 1.
- Flags change only in EXEC. JMP, BR, NOP and HALT preserve them.
- HALT: halted=1; absorbing. Only reset exits. pc_en is never asserted for HALT, so the PC keeps the address of the HALT instruction.
- FAULT: fault=1; absorbing until reset. IR is unchanged and no strobes are issued.
- imem_ack while imem_req=0 is ignored.
- Reset mid-operation: all outputs drop immediately. A pending fetch is abandoned and restarts from IDLE.
- Minimum cycles per instruction, with ack in the first FETCH cycle:
  - ALU: 4 (FETCH, DECODE, EXEC, UPDATE)
  - other instructions: 3

Optional Feature:
- Macro: PCSEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit) and state STEP_WAIT.
  - UPDATE goes to STEP_WAIT instead of FETCH. STEP_WAIT goes to FETCH on the first cycle step=1.
  - If step is held high, execution advances one instruction per pass; there is no edge detection.
  - Outputs in STEP_WAIT are the same as in FETCH-idle, with imem_req=0.
- Undefined: no step port and no STEP_WAIT state; UPDATE goes directly to FETCH.

Test Plan:
- Reset release, instr=0xE000 (NOP) acked immediately -> imem_req in cycle 1; pc_en pulse in cycle 3 with j_sele=pc_sele=0; next fetch in cycle 4.
- ALU 0x1234 with alu_n=1, alu_z=0, then BR 0xD205 (funct=1, label=5) -> alu_en one cycle; neg=1; BR UPDATE has pc_sele=1, label=0x005.
- BR 0xD405 (funct=2) with zer=0 -> UPDATE has pc_sele=0, j_sele=0 (increment); funct=6 variant is never taken even with all flags set.
- JMP 0xC1FF -> UPDATE has j_sele=1, adr_in=0x1FF, pc_sele=0; flags unchanged from the previous ALU op.
- imem_ack held 0 for TMO=15 cycles -> fault=1, imem_req=0 thereafter; rst low then high -> fault=0, fetch restarts. HALT 0xF000 -> halted=1, no further pc_en or imem_req.
- rst asserted during the EXEC cycle -> alu_en and flags cleared asynchronously. With PCSEQ_SINGLE_STEP_EN, step=0 holds STEP_WAIT with imem_req=0; a one-cycle step pulse fetches exactly one instruction.
